// File: rtl/ntt_mdc_sched.sv
// Purpose : job sequencer for the MDC NTT pipeline; feeds input BRAM reads, tracks latency, drives output BRAM writes.
// Latency : first read 1 cycle after accept; first write 1+DELAY_BRAM+LAT cycles after accept; done one cycle after last write.
// Backpr. : one job at a time, req_ready low while busy; output writes are never stalled.
module ntt_mdc_sched #(
    parameter int LOGN       = 8,
    parameter int DELAY_BRAM = 1,
    parameter int LAT_FNTT   = 64,
    parameter int LAT_INTT   = 72
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_req_valid,
    input  logic            i_req_intt,
    output logic            o_req_ready,
    output logic            o_rd_en,
    output logic [LOGN-2:0] o_rd_addr,
    output logic            o_pipe_start,
    output logic            o_pipe_intt,
    output logic            o_wr_en,
    output logic [LOGN-2:0] o_wr_addr,
    output logic            o_busy,
    output logic            o_done
);

    localparam int AW      = LOGN - 1;
    localparam int LAT_MAX = (LAT_FNTT > LAT_INTT) ? LAT_FNTT : LAT_INTT;
    localparam int CW      = $clog2(DELAY_BRAM + LAT_MAX + 2);

    // Counter value seen in the cycle just before the first write.
    localparam logic [CW-1:0] TGT_F     = CW'(DELAY_BRAM + LAT_FNTT - 1);
    localparam logic [CW-1:0] TGT_I     = CW'(DELAY_BRAM + LAT_INTT - 1);
    localparam logic [AW-1:0] ADDR_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          r_state;
    logic            r_req_ready;
    logic            r_rd_en;
    logic [AW-1:0]   r_rd_addr;
    logic            r_pipe_intt;
    logic            r_wr_en;
    logic [AW-1:0]   r_wr_addr;
    logic            r_busy;
    logic            r_done;
    logic            r_lat_run;
    logic [CW-1:0]   r_lat_cnt;

    logic [CW-1:0]   w_lat_tgt;
    logic            w_lat_hit;
    logic            w_rd_last;
    logic            w_wr_last;

    // Latency target follows the latched mode only, never the live request input.
    assign w_lat_tgt = r_pipe_intt ? TGT_I : TGT_F;
    assign w_lat_hit = r_lat_run && (r_lat_cnt == w_lat_tgt);
    assign w_rd_last = r_rd_en && (r_rd_addr == ADDR_LAST);
    assign w_wr_last = r_wr_en && (r_wr_addr == ADDR_LAST);

    // Job FSM; read stream, latency counter and write address run alongside the state so reads and writes may overlap.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_pipe_intt <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_lat_run   <= 1'b0;
            r_lat_cnt   <= '0;
        end else begin
            if (r_rd_en) begin
                r_rd_addr <= r_rd_addr + 1'b1;
                if (w_rd_last) begin
                    r_rd_en <= 1'b0;
                end
            end
            if (r_lat_run) begin
                if (w_lat_hit) begin
                    r_lat_run <= 1'b0;
                end else begin
                    r_lat_cnt <= r_lat_cnt + 1'b1;
                end
            end
            if (r_wr_en) begin
                r_wr_addr <= r_wr_addr + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (i_req_valid && r_req_ready) begin
                        r_state     <= S_FEED;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_pipe_intt <= i_req_intt;
                        r_rd_en     <= 1'b1;
                        r_rd_addr   <= '0;
                        r_wr_addr   <= '0;
                        r_lat_cnt   <= '0;
                        r_lat_run   <= 1'b1;
                    end
                end
                S_FEED: begin
                    // Short latency: start draining while the read stream is still running.
                    if (w_lat_hit) begin
                        r_state <= S_DRAIN;
                        r_wr_en <= 1'b1;
                    end else if (w_rd_last) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_lat_hit) begin
                        r_state <= S_DRAIN;
                        r_wr_en <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_wr_last) begin
                        r_wr_en <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Start strobe tracks read enable through the BRAM read latency.
    generate
        if (DELAY_BRAM == 0) begin : g_ps_direct
            assign o_pipe_start = r_rd_en;
        end else begin : g_ps_delay
            logic [DELAY_BRAM-1:0] r_ps_sr;

            // Shift line cleared on reset so no stale start reaches stage 0.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_ps_sr <= '0;
                end else begin
                    r_ps_sr <= (r_ps_sr << 1) | DELAY_BRAM'(r_rd_en);
                end
            end

            assign o_pipe_start = r_ps_sr[DELAY_BRAM-1];
        end
    endgenerate

    assign o_req_ready = r_req_ready;
    assign o_rd_en     = r_rd_en;
    assign o_rd_addr   = r_rd_addr;
    assign o_pipe_intt = r_pipe_intt;
    assign o_wr_en     = r_wr_en;
    assign o_wr_addr   = r_wr_addr;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule
